// File: rtl/sum_display.sv
// sum_display: converts the 9-bit adder result {Cout,Sum} to three BCD
// digits with a shift-and-add-3 FSM, then scans the digits onto a
// 4-digit active-low seven-segment display with leading-zero blanking.
//
// Handshake: there is no valid/ready pair on the input. The converter
// samples V whenever it sits in IDLE and V differs from the last
// converted value (or nothing has been converted since reset). Done is
// a one-cycle pulse in the same cycle that Bcd takes its new value.
// Every output is a flop, so Sum/Cout never reach an output directly.
`timescale 1ns/1ps

module sum_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Sum,
    input  logic        Cout,
    output logic [11:0] Bcd,
    output logic        Valid,
    output logic        Done,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic        Dp,
    output logic [1:0]  dbg_state
);

    localparam int SCAN_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [8:0]        value;
    logic              start;
    logic [8:0]        cap_q, cap_d;
    logic [8:0]        bin_q, bin_d;
    logic [11:0]       work_q, work_d;
    logic [11:0]       work_adj;
    logic [20:0]       shifted;
    logic [3:0]        cnt_q, cnt_d;
    logic [8:0]        last_q, last_d;
    logic              first_q, first_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        digit;
    logic              show;

    assign value = {Cout, Sum};
    // A new conversion starts on any change, and always on the first IDLE after reset.
    assign start = (state_q == IDLE) && (first_q || (value != last_q));

    assign Bcd       = bcd_q;
    assign Valid     = valid_q;
    assign Done      = done_q;
    assign Seg       = seg_q;
    assign An        = an_q;
    assign Dp        = 1'b1;
    assign dbg_state = state_q;

    // Converter state register.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Converter next-state: IDLE -> SHIFT (9 cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd8) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Converter outputs and datapath: capture, add-3/shift, publish result.
    always_comb begin
        cap_d   = cap_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        first_d = first_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            work_adj[i*4 +: 4] = (work_q[i*4 +: 4] >= 4'd5) ? work_q[i*4 +: 4] + 4'd3
                                                            : work_q[i*4 +: 4];
        end
        shifted = {work_adj, bin_q} << 1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_d  = value;
                    bin_d  = value;
                    work_d = 12'h000;
                    cnt_d  = 4'd0;
                end
            end
            SHIFT: begin
                work_d = shifted[20:9];
                bin_d  = shifted[8:0];
                cnt_d  = cnt_q + 4'd1;
            end
            DONE: begin
                bcd_d   = work_q;
                last_d  = cap_q;
                first_d = 1'b0;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan timing and registered digit select with leading-zero blanking.
    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
        an_d   = 4'b1111;
        digit  = 4'd0;
        show   = 1'b0;
        if (valid_q) begin
            case (idx_q)
                2'd0: begin
                    show  = 1'b1;
                    an_d  = 4'b1110;
                    digit = bcd_q[3:0];
                end
                2'd1: begin
                    if (bcd_q[11:8] != 4'd0 || bcd_q[7:4] != 4'd0) begin
                        show  = 1'b1;
                        an_d  = 4'b1101;
                        digit = bcd_q[7:4];
                    end
                end
                2'd2: begin
                    if (bcd_q[11:8] != 4'd0) begin
                        show  = 1'b1;
                        an_d  = 4'b1011;
                        digit = bcd_q[11:8];
                    end
                end
                default: ;
            endcase
        end
        seg_d = 7'b1111111;
        if (show) begin
            case (digit)
                4'd0:    seg_d = 7'b1000000;
                4'd1:    seg_d = 7'b1111001;
                4'd2:    seg_d = 7'b0100100;
                4'd3:    seg_d = 7'b0110000;
                4'd4:    seg_d = 7'b0011001;
                4'd5:    seg_d = 7'b0010010;
                4'd6:    seg_d = 7'b0000010;
                4'd7:    seg_d = 7'b1111000;
                4'd8:    seg_d = 7'b0000000;
                4'd9:    seg_d = 7'b0010000;
                default: seg_d = 7'b1111111;
            endcase
        end
    end

    // Datapath and display registers; reset aborts any conversion in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cap_q   <= 9'd0;
            bin_q   <= 9'd0;
            work_q  <= 12'h000;
            cnt_q   <= 4'd0;
            last_q  <= 9'd0;
            first_q <= 1'b1;
            bcd_q   <= 12'h000;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            first_q <= first_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

endmodule
